alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Parametrised successor to the EX-stage ALU control decoder: decodes ALUOp/funct, executes the operation and registers the result.
- Adds an iterative multi-cycle MUL, a valid/ready handshake on both sides, and a flush.
- Sits in the EX stage. The hazard unit uses in_ready_o as the EX stall source.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.
- MUL_BITS, 1, multiplier bits retired per MUL cycle; power of 2 that divides XLEN.
- SHAMT_W, $clog2(XLEN), shift-amount width taken from the low bits of data2_i.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous; discards any in-flight or held operation
- in_valid_i  in  1  operation presented
- in_ready_o  out  1  unit can accept an operation this cycle
- ALUOp_i  in  2  00 I-type, 01 branch compare, 10 R-type, 11 load/store address
- funct_i  in  10  {funct7, funct3}
- data1_i  in  XLEN  rs1 operand
- data2_i  in  XLEN  rs2 or immediate operand
- out_valid_o  out  1  result valid
- out_ready_i  in  1  downstream consumes the result
- data_o  out  XLEN  result
- zero_o  out  1  data_o == 0 (registered with data_o)
- illegal_o  out  1  held op had an undecodable funct (qualified by out_valid_o)

Behaviour:
- Reset (asynchronous, rst_i=1): state=IDLE, out_valid_o=0, data_o=0, zero_o=0, illegal_o=0, multiplier registers=0. in_ready_o=1 once reset deasserts.
- Accept: an operation is accepted when in_valid_i && in_ready_o.
- in_ready_o = (state==IDLE) && (!out_valid_o || out_ready_i); combinational. A new operation may be accepted in the same cycle the held result drains.
- Decode, ALUOp=10 (funct7_funct3):
  - 0000000_111 AND, 0000000_110 OR, 0000000_100 XOR
  - 0000000_001 SLL, 0000000_101 SRL, 0100000_101 SRA
  - 0000000_000 ADD, 0100000_000 SUB
  - 0000000_010 SLT (signed)
  - 0000001_000 MUL
  - anything else: result 0, illegal_o=1.
- Decode, ALUOp=00 (funct3 only):
  - 000 ADDI, 111 ANDI, 110 ORI, 100 XORI, 001 SLLI, 010 SLTI
  - 101 is SRAI when funct7[5]=1, else SRLI
  - 011: illegal, result 0.
- Decode, ALUOp=01: SUB. ALUOp=11: ADD.
- Arithmetic rules: modulo 2^XLEN. Shifts use data2_i[SHAMT_W-1:0]. SRA is sign-extending. SLT/SLTI return 1 or 0. MUL returns the low XLEN bits of the product; the signed/unsigned distinction is irrelevant for the low half.
- Single-cycle ops: result registered at the accept edge; out_valid_o=1 the next cycle (latency 1). State stays IDLE.
- MUL: accept edge latches multiplicand, multiplier and accumulator=0; state goes IDLE->MUL, counter=XLEN/MUL_BITS.
  - Each MUL cycle adds MUL_BITS partial products, shifts, and decrements the counter.
  - On the cycle the counter reaches 0: state->IDLE, data_o=accumulator, out_valid_o=1.
  - Total latency is XLEN/MUL_BITS+1 cycles from accept to out_valid_o (33 at the defaults).
- Output hold: data_o, zero_o and illegal_o stay stable while out_valid_o && !out_ready_i. They clear to out_valid_o=0 after a handshake unless a new result lands on the same edge.
- Flush: flush_i=1 at an edge forces state=IDLE and out_valid_o=0 and drops the held result. Flush wins over a simultaneous accept: an operation presented in the flush cycle is discarded. data_o value after flush is don't-care.
- Reset mid-MUL: aborts immediately. No result is produced.
- in_valid_i while the unit is busy: ignored, because in_ready_o=0. The source must hold its operands until accepted.

Test Plan:
- ADD 0x7FFFFFFF+1 (ALUOp=10, funct 0000000_000), out_ready_i=1 -> next cycle out_valid_o=1, data_o=0x80000000, zero_o=0. SUB 5-5 -> data_o=0, zero_o=1.
- SRAI data1=0x80000010, imm shamt=4, funct 0100000_101, ALUOp=00 -> data_o=0xF8000001. SRLI same operands -> 0x08000001. SLT -1 vs 1 -> 1.
- MUL 0x00012345*0x00000100, MUL_BITS=1 -> in_ready_o=0 for 32 cycles; out_valid_o at cycle 33 with data_o=0x01234500. Repeat with MUL_BITS=4 -> out_valid_o at cycle 9.
- Backpressure: out_ready_i=0 for 3 cycles after an AND result -> data_o held, in_ready_o=0. Releasing out_ready_i with in_valid_i=1 accepts the next op in the same cycle, with back-to-back results.
- flush_i at MUL cycle 10 -> out_valid_o never rises for that op. in_ready_o=1 the next cycle; a following ADD completes normally.
- Illegal funct 0000000_011 with ALUOp=10 -> out_valid_o=1, illegal_o=1, data_o=0. Assert rst_i mid-MUL -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct, executes single-cycle ops or an iterative MUL,
// and holds the registered result behind a valid/ready handshake.
module alu_exec_unit #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      ALUOp_i,
  input  logic [9:0]      funct_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] data_o,
  output logic            zero_o,
  output logic            illegal_o
);

  localparam int MUL_STEPS = XLEN / MUL_BITS;
  localparam int CNT_W     = $clog2(MUL_STEPS + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state;
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mplier;
  logic [XLEN-1:0]   acc;
  logic [XLEN-1:0]   acc_next;
  logic [CNT_W-1:0]  cnt;

  logic [XLEN-1:0]   result;
  logic              illegal;
  logic              is_mul;
  logic              accept;
  logic              lt;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]        funct3;

  assign in_ready_o = (state == S_IDLE) && (!out_valid_o || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;
  assign shamt      = data2_i[SHAMT_W-1:0];
  assign funct3     = funct_i[2:0];
  assign lt         = $signed(data1_i) < $signed(data2_i);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    is_mul  = 1'b0;
    case (ALUOp_i)
      2'b10: begin
        case (funct_i)
          10'b0000000_111: result = data1_i & data2_i;
          10'b0000000_110: result = data1_i | data2_i;
          10'b0000000_100: result = data1_i ^ data2_i;
          10'b0000000_001: result = data1_i << shamt;
          10'b0000000_101: result = data1_i >> shamt;
          10'b0100000_101: result = $unsigned($signed(data1_i) >>> shamt);
          10'b0000000_000: result = data1_i + data2_i;
          10'b0100000_000: result = data1_i - data2_i;
          10'b0000000_010: result = {{(XLEN-1){1'b0}}, lt};
          10'b0000001_000: is_mul = 1'b1;
          default:         illegal = 1'b1;
        endcase
      end
      2'b00: begin
        // I-type decodes on funct3 alone; funct7[5] only separates SRAI from SRLI
        case (funct3)
          3'b000:  result = data1_i + data2_i;
          3'b111:  result = data1_i & data2_i;
          3'b110:  result = data1_i | data2_i;
          3'b100:  result = data1_i ^ data2_i;
          3'b001:  result = data1_i << shamt;
          3'b010:  result = {{(XLEN-1){1'b0}}, lt};
          3'b101:  result = funct_i[8] ? $unsigned($signed(data1_i) >>> shamt)
                                       : (data1_i >> shamt);
          default: illegal = 1'b1;
        endcase
      end
      2'b01:   result = data1_i - data2_i;
      default: result = data1_i + data2_i;
    endcase
  end

  // One MUL iteration: retire MUL_BITS multiplier bits as shifted partial products
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < MUL_BITS; j++) begin
      if (mplier[j]) acc_next = acc_next + (mcand << j);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      out_valid_o <= 1'b0;
      data_o      <= '0;
      zero_o      <= 1'b0;
      illegal_o   <= 1'b0;
      mcand       <= '0;
      mplier      <= '0;
      acc         <= '0;
      cnt         <= '0;
    end else if (flush_i) begin
      state       <= S_IDLE;
      out_valid_o <= 1'b0;
      cnt         <= '0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              mcand  <= data1_i;
              mplier <= data2_i;
              acc    <= '0;
              cnt    <= CNT_W'(MUL_STEPS);
              state  <= S_MUL;
            end else begin
              data_o      <= result;
              zero_o      <= (result == '0);
              illegal_o   <= illegal;
              out_valid_o <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state       <= S_IDLE;
            data_o      <= acc_next;
            zero_o      <= (acc_next == '0);
            illegal_o   <= 1'b0;
            out_valid_o <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
